spi_reg_arb: RTL and testbench
==============================

Name: spi_reg_arb

Overview:
- Arbitrates the single register-file access port between two requesters: the SPI slave frame decoder (source 0) and the one-wire (OWT) decoder (source 1).
- Captures single-cycle requests, grants them round-robin and issues one wen/ren pulse per transaction.
- Waits for the register ack, with a timeout.
- Enforces a minimum idle gap before the bus switches from one source to the other (mixed-access gap).

Parameters:
REG_AW, 7, register address width
REG_DW, 8, register data width
MIX_GAP, 100, minimum cycles between completing one source and issuing the other source
TMO_CYC, 15, cycles in WAIT without ack before timeout

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_spi_req  in  1  single-cycle request pulse, source 0
i_spi_wr  in  1  1=write 0=read, sampled with i_spi_req
i_spi_addr  in  REG_AW  address, sampled with i_spi_req
i_spi_wdata  in  REG_DW  write data, sampled with i_spi_req
o_spi_done  out  1  single-cycle completion pulse
o_spi_rdata  out  REG_DW  read data, valid while o_spi_done=1
o_spi_err  out  1  pulse with o_spi_done on timeout; also pulses one cycle after a dropped request
i_owt_req, i_owt_wr, i_owt_addr, i_owt_wdata  in  1/1/REG_AW/REG_DW  same as SPI, source 1
o_owt_done, o_owt_rdata, o_owt_err  out  1/REG_DW/1  same as SPI, source 1
o_reg_wen  out  1  write strobe, one cycle
o_reg_ren  out  1  read strobe, one cycle
o_reg_addr  out  REG_AW  register address, held from ISSUE through DONE
o_reg_wdata  out  REG_DW  register write data, held from ISSUE through DONE
i_reg_ack  in  1  register access complete (read or write)
i_reg_rdata  in  REG_DW  read data, sampled with i_reg_ack

Behaviour:
- Reset: all outputs 0; FSM=IDLE; pending flags 0; rr pointer favours SPI; last_src=NONE; gap_cnt=MIX_GAP (saturated). Reset mid-transaction aborts it with no done pulse.
- Request capture, per source:
  - A req pulse when the source is not pending and not in flight sets pending and latches wr/addr/wdata.
  - A req pulse while pending or in flight is dropped; the source's err pulses next cycle with done=0.
  - Pending clears on grant.
- IDLE:
  - Eligible source: pending, and (src==last_src, or last_src==NONE, or gap_cnt==MIX_GAP).
  - Both eligible: grant the source not granted last (rr), then toggle the pointer.
  - On grant go to ISSUE next cycle. Latency: req at N, pending at N+1, ISSUE (strobe high) at N+2.
- ISSUE (1 cycle):
  - o_reg_wen or o_reg_ren = 1; addr/wdata driven from the latch; tmo_cnt=0.
  - i_reg_ack=1 in this cycle goes to DONE; otherwise go to WAIT.
- WAIT:
  - i_reg_ack goes to DONE, capturing i_reg_rdata.
  - Otherwise tmo_cnt++. At tmo_cnt==TMO_CYC-1 without ack, go to DONE with timeout flag set and rdata forced to 0.
- DONE (1 cycle):
  - Granted source's done=1 with rdata; err=timeout flag.
  - last_src=granted source; gap_cnt loads 0.
  - Next state IDLE.
  - Writes drive rdata=0.
- gap_cnt: width $clog2(MIX_GAP+1); increments each cycle outside DONE; saturates at MIX_GAP.
  - Same-source back-to-back is never gap-blocked.
  - Timing: ack sampled at A, DONE at A+1, other-source ISSUE no earlier than A+MIX_GAP+2.
- i_reg_ack outside ISSUE/WAIT is ignored.
- A new req from the in-flight source during DONE is dropped (err). It is accepted from the cycle after DONE.

Decomposition:
- Package spi_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - src_t enum {SRC_SPI, SRC_OWT, SRC_NONE}
  - default REG_AW/REG_DW constants
- Sub-module spi_arb_req_hold, instantiated twice: pending flag, request latch, drop detection/err pulse. Inputs are req/fields/grant/inflight; outputs are pending and the latched fields.

Test Plan:
- SPI write addr=0x12 wdata=0xA5 at cycle N, ack in ISSUE -> o_reg_wen=1 at N+2 with addr 0x12 / wdata 0xA5; o_spi_done=1 at N+3, err=0.
- OWT read addr=0x05, ack with rdata=0x3C two cycles after ISSUE -> o_reg_ren one cycle; o_owt_done with o_owt_rdata=0x3C, ack cycle+1.
- SPI and OWT req in the same cycle, MIX_GAP=4 -> SPI issued first. OWT ISSUE exactly A+6 after SPI ack cycle A. Then a new SPI req is granted before any further OWT request.
- SPI read, no ack, TMO_CYC=15 -> o_spi_done with o_spi_err=1 and rdata=0x00 at ISSUE+16. The next SPI request proceeds normally.
- Second SPI req while the first is pending -> o_spi_err pulse next cycle with no done. Only one strobe is issued, using the first address.
- Assert i_rst during WAIT -> all outputs 0 and no done. After release, an OWT req is issued without gap delay at N+2.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and default widths for the SPI/OWT register-port arbiter.
package spi_arb_pkg;

    localparam int unsigned DEF_REG_AW = 7;
    localparam int unsigned DEF_REG_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_SPI  = 2'd0,
        SRC_OWT  = 2'd1,
        SRC_NONE = 2'd2
    } src_t;

endpackage

// File: rtl/spi_reg_arb_if.sv
// Requester and register-file signals of the arbiter.
// master: arbiter side. slave: requesters plus register file.
interface spi_reg_arb_if #(
    parameter int unsigned REG_AW = spi_arb_pkg::DEF_REG_AW,
    parameter int unsigned REG_DW = spi_arb_pkg::DEF_REG_DW
) ();

    logic              i_spi_req;
    logic              i_spi_wr;
    logic [REG_AW-1:0] i_spi_addr;
    logic [REG_DW-1:0] i_spi_wdata;
    logic              o_spi_done;
    logic [REG_DW-1:0] o_spi_rdata;
    logic              o_spi_err;

    logic              i_owt_req;
    logic              i_owt_wr;
    logic [REG_AW-1:0] i_owt_addr;
    logic [REG_DW-1:0] i_owt_wdata;
    logic              o_owt_done;
    logic [REG_DW-1:0] o_owt_rdata;
    logic              o_owt_err;

    logic              o_reg_wen;
    logic              o_reg_ren;
    logic [REG_AW-1:0] o_reg_addr;
    logic [REG_DW-1:0] o_reg_wdata;
    logic              i_reg_ack;
    logic [REG_DW-1:0] i_reg_rdata;

    modport master (
        input  i_spi_req, i_spi_wr, i_spi_addr, i_spi_wdata,
        output o_spi_done, o_spi_rdata, o_spi_err,
        input  i_owt_req, i_owt_wr, i_owt_addr, i_owt_wdata,
        output o_owt_done, o_owt_rdata, o_owt_err,
        output o_reg_wen, o_reg_ren, o_reg_addr, o_reg_wdata,
        input  i_reg_ack, i_reg_rdata
    );

    modport slave (
        output i_spi_req, i_spi_wr, i_spi_addr, i_spi_wdata,
        input  o_spi_done, o_spi_rdata, o_spi_err,
        output i_owt_req, i_owt_wr, i_owt_addr, i_owt_wdata,
        input  o_owt_done, o_owt_rdata, o_owt_err,
        input  o_reg_wen, o_reg_ren, o_reg_addr, o_reg_wdata,
        output i_reg_ack, i_reg_rdata
    );

endinterface

// File: rtl/spi_arb_req_hold.sv
// Per-source request capture: pending flag, field latch and drop error pulse.
module spi_arb_req_hold import spi_arb_pkg::*; #(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned REG_DW = DEF_REG_DW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [REG_AW-1:0] i_addr,
    input  logic [REG_DW-1:0] i_wdata,
    input  logic              i_grant,
    input  logic              i_inflight,
    output logic              o_pending,
    output logic              o_wr,
    output logic [REG_AW-1:0] o_addr,
    output logic [REG_DW-1:0] o_wdata,
    output logic              o_drop_err
);

    logic              pending_q;
    logic              wr_q;
    logic [REG_AW-1:0] addr_q;
    logic [REG_DW-1:0] wdata_q;
    logic              drop_q;
    logic              busy;

    // A request arriving while this source already owns a slot is dropped.
    assign busy = pending_q | i_inflight;

    // Accept or drop requests; the latch only moves on acceptance so it stays
    // stable for the whole transaction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= i_req & busy;
            if (i_req && !busy) begin
                pending_q <= 1'b1;
                wr_q      <= i_wr;
                addr_q    <= i_addr;
                wdata_q   <= i_wdata;
            end else if (i_grant) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign o_pending  = pending_q;
    assign o_wr       = wr_q;
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_drop_err = drop_q;

endmodule

// File: rtl/spi_reg_arb.sv
// Round-robin arbiter between the SPI and OWT decoders for the single register
// port, with ack timeout and a minimum idle gap when switching sources.
module spi_reg_arb import spi_arb_pkg::*; #(
    parameter int unsigned REG_AW  = DEF_REG_AW,
    parameter int unsigned REG_DW  = DEF_REG_DW,
    parameter int unsigned MIX_GAP = 100,
    parameter int unsigned TMO_CYC = 15
) (
    input logic           i_clk,
    input logic           i_rst,
    spi_reg_arb_if.master bus
);

    localparam int unsigned GAP_W = (MIX_GAP > 0) ? $clog2(MIX_GAP + 1) : 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    state_t            state_q, state_d;
    src_t              gnt_q, gnt_d;
    src_t              last_q, last_d;
    logic              rr_q, rr_d;        // 0: SPI wins a tie, 1: OWT wins
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [REG_DW-1:0] rdata_q, rdata_d;

    logic              spi_pend, owt_pend;
    logic              spi_wr, owt_wr;
    logic [REG_AW-1:0] spi_addr, owt_addr;
    logic [REG_DW-1:0] spi_wdata, owt_wdata;
    logic              spi_drop, owt_drop;
    logic              spi_gnt, owt_gnt;
    logic              spi_infl, owt_infl;
    logic              spi_elig, owt_elig, gap_ok;
    logic              cur_wr;
    logic [REG_AW-1:0] cur_addr;
    logic [REG_DW-1:0] cur_wdata;
    logic              active;

    spi_arb_req_hold #(
        .REG_AW (REG_AW),
        .REG_DW (REG_DW)
    ) u_hold_spi (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (bus.i_spi_req),
        .i_wr       (bus.i_spi_wr),
        .i_addr     (bus.i_spi_addr),
        .i_wdata    (bus.i_spi_wdata),
        .i_grant    (spi_gnt),
        .i_inflight (spi_infl),
        .o_pending  (spi_pend),
        .o_wr       (spi_wr),
        .o_addr     (spi_addr),
        .o_wdata    (spi_wdata),
        .o_drop_err (spi_drop)
    );

    spi_arb_req_hold #(
        .REG_AW (REG_AW),
        .REG_DW (REG_DW)
    ) u_hold_owt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (bus.i_owt_req),
        .i_wr       (bus.i_owt_wr),
        .i_addr     (bus.i_owt_addr),
        .i_wdata    (bus.i_owt_wdata),
        .i_grant    (owt_gnt),
        .i_inflight (owt_infl),
        .o_pending  (owt_pend),
        .o_wr       (owt_wr),
        .o_addr     (owt_addr),
        .o_wdata    (owt_wdata),
        .o_drop_err (owt_drop)
    );

    // Transaction ownership, eligibility and the granted source's latched fields.
    always_comb begin
        active    = (state_q != IDLE);
        spi_infl  = active && (gnt_q == SRC_SPI);
        owt_infl  = active && (gnt_q == SRC_OWT);
        gap_ok    = (gap_q == GAP_W'(MIX_GAP));
        spi_elig  = spi_pend && ((last_q == SRC_SPI) || (last_q == SRC_NONE) || gap_ok);
        owt_elig  = owt_pend && ((last_q == SRC_OWT) || (last_q == SRC_NONE) || gap_ok);
        cur_wr    = (gnt_q == SRC_OWT) ? owt_wr    : spi_wr;
        cur_addr  = (gnt_q == SRC_OWT) ? owt_addr  : spi_addr;
        cur_wdata = (gnt_q == SRC_OWT) ? owt_wdata : spi_wdata;
    end

    // Next-state: arbitration in IDLE, strobe, ack/timeout wait, completion.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        tmo_flag_d = tmo_flag_q;
        rdata_d    = rdata_q;
        spi_gnt    = 1'b0;
        owt_gnt    = 1'b0;
        gap_d      = gap_ok ? gap_q : gap_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (spi_elig && (!owt_elig || !rr_q)) begin
                    spi_gnt = 1'b1;
                    gnt_d   = SRC_SPI;
                    rr_d    = 1'b1;
                    state_d = ISSUE;
                end else if (owt_elig) begin
                    owt_gnt = 1'b1;
                    gnt_d   = SRC_OWT;
                    rr_d    = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d      = '0;
                tmo_flag_d = 1'b0;
                if (bus.i_reg_ack) begin
                    rdata_d = cur_wr ? '0 : bus.i_reg_rdata;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_reg_ack) begin
                    rdata_d = cur_wr ? '0 : bus.i_reg_rdata;
                    state_d = DONE;
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    tmo_flag_d = 1'b1;
                    rdata_d    = '0;
                    state_d    = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The gap count reads 0 during DONE, so the ack cycle anchors the gap.
        if (state_d == DONE) begin
            gap_d = '0;
        end
    end

    // State registers; reset aborts any transaction without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            gnt_q      <= SRC_NONE;
            last_q     <= SRC_NONE;
            rr_q       <= 1'b0;
            gap_q      <= GAP_W'(MIX_GAP);
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            tmo_flag_q <= tmo_flag_d;
            rdata_q    <= rdata_d;
        end
    end

    // Register-bus strobes and per-source completion outputs.
    always_comb begin
        bus.o_reg_wen   = (state_q == ISSUE) && cur_wr;
        bus.o_reg_ren   = (state_q == ISSUE) && !cur_wr;
        bus.o_reg_addr  = active ? cur_addr  : '0;
        bus.o_reg_wdata = active ? cur_wdata : '0;
        bus.o_spi_done  = (state_q == DONE) && (gnt_q == SRC_SPI);
        bus.o_owt_done  = (state_q == DONE) && (gnt_q == SRC_OWT);
        bus.o_spi_rdata = bus.o_spi_done ? rdata_q : '0;
        bus.o_owt_rdata = bus.o_owt_done ? rdata_q : '0;
        bus.o_spi_err   = spi_drop | (bus.o_spi_done & tmo_flag_q);
        bus.o_owt_err   = owt_drop | (bus.o_owt_done & tmo_flag_q);
    end

endmodule

// File: tb/tb_spi_reg_arb.sv
// Bench for spi_reg_arb: directed scenarios plus random single transactions,
// checked against a transaction-level timing model.
module tb_spi_reg_arb;

    localparam int AW      = 7;
    localparam int DW      = 8;
    localparam int MIX_GAP = 4;
    localparam int TMO_CYC = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    spi_reg_arb_if #(.REG_AW(AW), .REG_DW(DW)) bus ();

    spi_reg_arb #(
        .REG_AW  (AW),
        .REG_DW  (DW),
        .MIX_GAP (MIX_GAP),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Register-file responder and event recorder
    logic          ack_on = 1'b1;
    int            ack_dly = 0;
    logic [DW-1:0] ack_data = '0;
    logic          stray_req = 1'b0;
    logic          ack_armed = 1'b0;
    int            ack_at = 0;
    int            iss_cyc_q[$];
    logic [AW-1:0] iss_addr_q[$];
    logic [DW-1:0] iss_wdata_q[$];
    logic          iss_wr_q[$];
    int            spi_done_n = 0, owt_done_n = 0, spi_drop_n = 0, owt_drop_n = 0;
    int            spi_done_cyc, owt_done_cyc, spi_drop_cyc, owt_drop_cyc;
    logic [DW-1:0] spi_done_rd, owt_done_rd;
    logic          spi_done_err, owt_done_err;

    always @(negedge clk) begin
        bus.i_reg_ack = 1'b0;
        if (stray_req) begin
            bus.i_reg_ack   = 1'b1;
            bus.i_reg_rdata = 8'h77;
            stray_req       = 1'b0;
        end
        if (bus.o_reg_wen || bus.o_reg_ren) begin
            iss_cyc_q.push_back(cyc);
            iss_addr_q.push_back(bus.o_reg_addr);
            iss_wdata_q.push_back(bus.o_reg_wdata);
            iss_wr_q.push_back(bus.o_reg_wen);
            if (ack_on) begin
                ack_armed = 1'b1;
                ack_at    = cyc + ack_dly;
            end
        end
        if (ack_armed && cyc == ack_at) begin
            bus.i_reg_ack   = 1'b1;
            bus.i_reg_rdata = ack_data;
            ack_armed       = 1'b0;
        end
        if (bus.o_spi_done) begin
            spi_done_n++; spi_done_cyc = cyc;
            spi_done_rd = bus.o_spi_rdata; spi_done_err = bus.o_spi_err;
        end else if (bus.o_spi_err) begin
            spi_drop_n++; spi_drop_cyc = cyc;
        end
        if (bus.o_owt_done) begin
            owt_done_n++; owt_done_cyc = cyc;
            owt_done_rd = bus.o_owt_rdata; owt_done_err = bus.o_owt_err;
        end else if (bus.o_owt_err) begin
            owt_drop_n++; owt_drop_cyc = cyc;
        end
    end

    // Model state: last completed source (-1 none) and its done cycle
    int m_last = -1;
    int m_last_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int src, input logic req, input logic wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (src == 0) begin
            bus.i_spi_req = req; bus.i_spi_wr = wr;
            bus.i_spi_addr = addr; bus.i_spi_wdata = wdata;
        end else begin
            bus.i_owt_req = req; bus.i_owt_wr = wr;
            bus.i_owt_addr = addr; bus.i_owt_wdata = wdata;
        end
    endtask

    function automatic int exp_issue(input int src, input int r);
        int e = r + 2;
        if (m_last >= 0 && m_last != src && m_last_done + MIX_GAP + 1 > e)
            e = m_last_done + MIX_GAP + 1;
        return e;
    endfunction

    task automatic check_outs_zero(input string tag);
        logic [36:0] outs;
        outs = {bus.o_spi_done, bus.o_spi_rdata, bus.o_spi_err, bus.o_owt_done,
                bus.o_owt_rdata, bus.o_owt_err, bus.o_reg_wen, bus.o_reg_ren,
                bus.o_reg_addr, bus.o_reg_wdata};
        chk(tag, outs, 0);
    endtask

    // One request from one source, checked end to end against the model
    task automatic run_txn(input int src, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int dly, input logic ackon,
                           input logic [DW-1:0] rd);
        int r, e_iss, e_done, n_iss0, n_s0, n_o0, w;
        ack_on = ackon; ack_dly = dly; ack_data = rd;
        n_iss0 = iss_cyc_q.size(); n_s0 = spi_done_n; n_o0 = owt_done_n;
        @(posedge clk); #1;
        r = cyc;
        drive_req(src, 1'b1, wr, addr, wdata);
        @(posedge clk); #1;
        drive_req(src, 1'b0, 1'b0, '0, '0);
        e_iss  = exp_issue(src, r);
        e_done = ackon ? e_iss + dly + 1 : e_iss + TMO_CYC + 1;
        w = 0;
        while (((src == 0) ? spi_done_n : owt_done_n) == ((src == 0) ? n_s0 : n_o0)
               && w < 100) begin
            @(negedge clk); w++;
        end
        chk("done_count", (src == 0) ? spi_done_n - n_s0 : owt_done_n - n_o0, 1);
        chk("other_done_count", (src == 0) ? owt_done_n - n_o0 : spi_done_n - n_s0, 0);
        chk("issue_count", iss_cyc_q.size() - n_iss0, 1);
        if (iss_cyc_q.size() > n_iss0) begin
            chk("issue_cycle", iss_cyc_q[n_iss0], e_iss);
            chk("issue_wen", iss_wr_q[n_iss0], wr);
            chk("issue_addr", iss_addr_q[n_iss0], addr);
            chk("issue_wdata", iss_wdata_q[n_iss0], wdata);
        end
        chk("done_cycle", (src == 0) ? spi_done_cyc : owt_done_cyc, e_done);
        chk("done_rdata", (src == 0) ? spi_done_rd : owt_done_rd, (wr || !ackon) ? 8'h00 : rd);
        chk("done_err", (src == 0) ? spi_done_err : owt_done_err, !ackon);
        m_last = src; m_last_done = e_done;
    endtask

    initial begin
        int r, n_iss0, n_s0, n_o0, n_d0, w;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_outs_zero("reset_outputs");
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_outs_zero("idle_outputs");

        // Stray ack while idle must be ignored
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_ack_issue", iss_cyc_q.size(), 0);
        chk("stray_ack_done", spi_done_n + owt_done_n, 0);

        // SPI write, ack in ISSUE
        run_txn(0, 1'b1, 7'h12, 8'hA5, 0, 1'b1, 8'h00);
        // OWT read, ack two cycles after ISSUE
        run_txn(1, 1'b0, 7'h05, 8'h00, 2, 1'b1, 8'h3C);

        // Simultaneous requests: SPI wins, OWT waits out the gap
        repeat (10) @(negedge clk);
        ack_on = 1'b1; ack_dly = 0;
        n_iss0 = iss_cyc_q.size(); n_o0 = owt_done_n;
        @(posedge clk); #1;
        r = cyc;
        drive_req(0, 1'b1, 1'b1, 7'h21, 8'h11);
        drive_req(1, 1'b1, 1'b1, 7'h42, 8'h22);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        w = 0;
        while (owt_done_n == n_o0 && w < 100) begin @(negedge clk); w++; end
        chk("both_issue_count", iss_cyc_q.size() - n_iss0, 2);
        if (iss_cyc_q.size() >= n_iss0 + 2) begin
            chk("both_first_addr", iss_addr_q[n_iss0], 7'h21);
            chk("both_first_cycle", iss_cyc_q[n_iss0], r + 2);
            chk("both_second_addr", iss_addr_q[n_iss0 + 1], 7'h42);
            chk("both_second_cycle", iss_cyc_q[n_iss0 + 1], (r + 2) + MIX_GAP + 2);
        end
        chk("both_spi_done", spi_done_cyc, r + 3);
        chk("both_owt_done", owt_done_cyc, r + MIX_GAP + 5);
        m_last = 1; m_last_done = r + MIX_GAP + 5;
        run_txn(0, 1'b0, 7'h33, 8'h00, 1, 1'b1, 8'h5A);

        // SPI read timeout, then a normal SPI read
        run_txn(0, 1'b0, 7'h44, 8'h00, 0, 1'b0, 8'hFF);
        run_txn(0, 1'b0, 7'h45, 8'h00, 1, 1'b1, 8'h96);

        // Second SPI request while pending is dropped
        ack_on = 1'b1; ack_dly = 1; ack_data = 8'h00;
        n_iss0 = iss_cyc_q.size(); n_s0 = spi_done_n; n_d0 = spi_drop_n;
        @(posedge clk); #1;
        r = cyc;
        drive_req(0, 1'b1, 1'b1, 7'h50, 8'hC3);
        @(posedge clk); #1;
        drive_req(0, 1'b1, 1'b1, 7'h51, 8'h3C);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        w = 0;
        while (spi_done_n == n_s0 && w < 100) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        chk("drop_err_count", spi_drop_n - n_d0, 1);
        chk("drop_err_cycle", spi_drop_cyc, r + 2);
        chk("drop_issue_count", iss_cyc_q.size() - n_iss0, 1);
        if (iss_cyc_q.size() > n_iss0) chk("drop_issue_addr", iss_addr_q[n_iss0], 7'h50);
        chk("drop_done_count", spi_done_n - n_s0, 1);
        m_last = 0; m_last_done = spi_done_cyc;

        // Reset during WAIT aborts without done
        ack_on = 1'b0;
        n_iss0 = iss_cyc_q.size(); n_s0 = spi_done_n;
        @(posedge clk); #1;
        r = cyc;
        drive_req(0, 1'b1, 1'b0, 7'h60, 8'h00);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        while (cyc < r + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outs_zero("reset_in_wait");
        @(posedge clk); #1; rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset_no_done", spi_done_n - n_s0, 0);
        chk("reset_one_strobe", iss_cyc_q.size() - n_iss0, 1);
        m_last = -1;
        run_txn(1, 1'b1, 7'h0F, 8'hE7, 0, 1'b1, 8'h00);

        // Random single transactions
        for (int k = 0; k < 30; k++) begin
            int src, dly;
            logic wr, ackon;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            src   = int'($urandom_range(1, 0));
            wr    = 1'($urandom);
            a     = AW'($urandom);
            wd    = DW'($urandom);
            rd    = DW'($urandom);
            dly   = int'($urandom_range(5, 0));
            ackon = ($urandom_range(5, 0) != 0);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            run_txn(src, wr, a, wd, dly, ackon, rd);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
